// File: rtl/crypto_engine_arbiter.sv
//============================================================================
// Module  : crypto_engine_arbiter
// Brief   : Round-robin ownership arbiter for the RSA/AES/SHA engines; each
//           engine tracks its owner's job from grant through interrupt to
//           release. Optional RUN watchdog: define CRYPTO_ARB_TIMEOUT_EN.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module crypto_engine_arbiter #(
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = 65535,
    localparam int IDW            = $clog2(NUM_REQ)
) (
    input  logic                 hclk,
    input  logic                 hrst_b,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] req_eng,
    input  logic [NUM_REQ-1:0]   start,
    input  logic [NUM_REQ-1:0]   rel,
    input  logic                 rsa_intr,
    input  logic                 aes_intr,
    input  logic                 sha_intr,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   err,
    output logic [2:0]           eng_busy,
    output logic [IDW-1:0]       rsa_owner,
    output logic [IDW-1:0]       aes_owner,
    output logic [IDW-1:0]       sha_owner
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_OWNED = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [NUM_REQ-1:0] c_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [2:0]         w_intr;
    logic [NUM_REQ-1:0] w_gnt_e  [3];
    logic [NUM_REQ-1:0] w_done_e [3];
    logic [NUM_REQ-1:0] w_err_e  [3];
    logic [IDW-1:0]     w_owner_e[3];

    assign w_intr = {sha_intr, aes_intr, rsa_intr};

    for (genvar e = 0; e < 3; e++) begin : g_eng
        logic [1:0]         r_state;
        logic [IDW-1:0]     r_owner;
        logic [IDW-1:0]     r_ptr;
        logic               r_intr_q;
        logic [NUM_REQ-1:0] w_elig;
        logic               w_any;
        logic [IDW-1:0]     w_win;
        logic [IDW-1:0]     w_ptr_nxt;
        logic               w_start;
        logic               w_rel;
        logic               w_edge;

        // A requester that already owns any engine is not eligible again.
        always_comb begin
            w_elig = '0;
            w_any  = 1'b0;
            w_win  = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                w_elig[i] = req[i] && (req_eng[2*i +: 2] == 2'(e)) && !gnt[i];
            end
            // Scan downward so the closest index at/after the pointer wins last.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (w_elig[(int'(r_ptr) + k) % NUM_REQ]) begin
                    w_any = 1'b1;
                    w_win = IDW'((int'(r_ptr) + k) % NUM_REQ);
                end
            end
        end

        assign w_ptr_nxt = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
        assign w_start   = start[r_owner];
        assign w_rel     = rel[r_owner];
        assign w_edge    = w_intr[e] & ~r_intr_q;

`ifdef CRYPTO_ARB_TIMEOUT_EN
        localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);
        logic [15:0] r_cnt;
        logic        r_err;

        always_ff @(posedge hclk or negedge hrst_b) begin
            if (!hrst_b) begin
                r_cnt <= '0;
                r_err <= 1'b0;
            end else if (r_state != c_IDLE && w_rel) begin
                r_cnt <= '0;
                r_err <= 1'b0;
            end else if (r_state == c_OWNED && w_start) begin
                r_cnt <= '0;
            end else if (r_state == c_RUN) begin
                r_cnt <= r_cnt + 16'd1;
                if (!w_edge && r_cnt == c_TO_LAST) begin
                    r_err <= 1'b1;
                end
            end
        end

        assign w_err_e[e] = r_err ? (c_ONE << r_owner) : '0;
`else
        assign w_err_e[e] = '0;
`endif

        always_ff @(posedge hclk or negedge hrst_b) begin
            if (!hrst_b) begin
                r_state  <= c_IDLE;
                r_owner  <= '0;
                r_ptr    <= '0;
                r_intr_q <= 1'b0;
            end else begin
                r_intr_q <= w_intr[e];
                case (r_state)
                    c_IDLE: begin
                        if (w_any) begin
                            r_state <= c_OWNED;
                            r_owner <= w_win;
                            r_ptr   <= w_ptr_nxt;
                        end
                    end
                    c_OWNED: begin
                        if (w_rel) begin
                            r_state <= c_IDLE;
                        end else if (w_start) begin
                            r_state <= c_RUN;
                        end
                    end
                    c_RUN: begin
                        if (w_rel) begin
                            r_state <= c_IDLE;
                        end else if (w_edge) begin
                            r_state <= c_DONE;
`ifdef CRYPTO_ARB_TIMEOUT_EN
                        end else if (r_cnt == c_TO_LAST) begin
                            r_state <= c_DONE;
`endif
                        end
                    end
                    c_DONE: begin
                        if (w_rel) begin
                            r_state <= c_IDLE;
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end

        assign eng_busy[e]  = (r_state != c_IDLE);
        assign w_gnt_e[e]   = (r_state != c_IDLE) ? (c_ONE << r_owner) : '0;
        assign w_done_e[e]  = (r_state == c_DONE) ? (c_ONE << r_owner) : '0;
        assign w_owner_e[e] = (r_state != c_IDLE) ? r_owner : '0;
    end

    always_comb begin
        gnt  = w_gnt_e[0]  | w_gnt_e[1]  | w_gnt_e[2];
        done = w_done_e[0] | w_done_e[1] | w_done_e[2];
        err  = w_err_e[0]  | w_err_e[1]  | w_err_e[2];
    end

    assign rsa_owner = w_owner_e[0];
    assign aes_owner = w_owner_e[1];
    assign sha_owner = w_owner_e[2];

endmodule

`default_nettype wire
